// File: rtl/b_syn_down_timer.sv
// Loadable synchronous down counter: counts a loaded value to zero on enabled edges,
// pulses tc for one cycle at zero, then stops (one-shot) or reloads (periodic).
module b_syn_down_timer #(
  parameter int WIDTH       = 4,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             re,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  output logic [WIDTH-1:0] c,
  output logic             tc,
  output logic             busy
);

  typedef enum logic {IDLE, COUNT} state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rld_q, rld_d;
  logic             tc_q, tc_d;

  always_ff @(posedge clk) begin
    if (re) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rld_q   <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rld_q   <= rld_d;
      tc_q    <= tc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rld_d   = rld_q;
    tc_d    = 1'b0;
    if (ld) begin
      // A load never decrements in the same cycle, even with en high.
      cnt_d   = d;
      rld_d   = d;
      state_d = (d != '0) ? COUNT : IDLE;
    end else if (state_q == COUNT && en) begin
      if (cnt_q > ONE) begin
        cnt_d = cnt_q - ONE;
      end else if (cnt_q == ONE) begin
        cnt_d = '0;
        tc_d  = 1'b1;
        if (!AUTO_RELOAD) state_d = IDLE;
      end else if (AUTO_RELOAD) begin
        // Zero is the last slot of a period; the next enabled edge restarts it.
        cnt_d = rld_q;
      end else begin
        state_d = IDLE;
      end
    end
  end

  assign c    = cnt_q;
  assign tc   = tc_q;
  assign busy = (state_q == COUNT);

endmodule

// File: tb/tb_b_syn_down_timer.sv
// Scoreboard bench for b_syn_down_timer: one-shot and periodic instances share stimulus,
// a reference model pushes expected outputs per edge, a monitor pops and compares.
module tb_b_syn_down_timer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         re  = 1'b1;
  logic         ld  = 1'b0;
  logic [W-1:0] d   = '0;
  logic         en  = 1'b0;
  logic [W-1:0] c0, c1;
  logic         tc0, tc1, busy0, busy1;

  always #5 clk = ~clk;

  b_syn_down_timer #(.WIDTH(W), .AUTO_RELOAD(1'b0)) dut_os (
    .clk(clk), .re(re), .ld(ld), .d(d), .en(en), .c(c0), .tc(tc0), .busy(busy0));
  b_syn_down_timer #(.WIDTH(W), .AUTO_RELOAD(1'b1)) dut_pr (
    .clk(clk), .re(re), .ld(ld), .d(d), .en(en), .c(c1), .tc(tc1), .busy(busy1));

  typedef struct {
    int c0; int tc0; int busy0;
    int c1; int tc1; int busy1;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: remaining count, saved period start, running flag, per mode.
  int m_cnt[2], m_rld[2], m_run[2], m_tc[2];

  task automatic model_step(input int i, input bit r, input bit l, input int dv, input bit e);
    int is_periodic;
    is_periodic = i;
    if (r) begin
      m_cnt[i] = 0; m_rld[i] = 0; m_run[i] = 0; m_tc[i] = 0;
    end else if (l) begin
      m_cnt[i] = dv; m_rld[i] = dv; m_run[i] = (dv != 0); m_tc[i] = 0;
    end else if (m_run[i] != 0 && e) begin
      if (m_cnt[i] == 0) begin
        m_cnt[i] = m_rld[i];
        m_tc[i]  = 0;
      end else begin
        m_cnt[i] = m_cnt[i] - 1;
        m_tc[i]  = (m_cnt[i] == 0);
        if (m_tc[i] != 0 && is_periodic == 0) m_run[i] = 0;
      end
    end else begin
      m_tc[i] = 0;
    end
  endtask

  task automatic cyc(input bit r, input bit l, input int dv, input bit e);
    exp_t x;
    @(negedge clk);
    re = r; ld = l; d = W'(dv); en = e;
    for (int i = 0; i < 2; i++) model_step(i, r, l, dv, e);
    x.c0 = m_cnt[0]; x.tc0 = m_tc[0]; x.busy0 = m_run[0];
    x.c1 = m_cnt[1]; x.tc1 = m_tc[1]; x.busy1 = m_run[1];
    exp_q.push_back(x);
  endtask

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  // Monitor: the timer presents a new registered result every edge.
  initial begin : monitor
    exp_t x;
    int   ptc0, ptc1;
    ptc0 = 0; ptc1 = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        check("oneshot_c",    int'(c0),    x.c0);
        check("oneshot_tc",   int'(tc0),   x.tc0);
        check("oneshot_busy", int'(busy0), x.busy0);
        check("periodic_c",    int'(c1),    x.c1);
        check("periodic_tc",   int'(tc1),   x.tc1);
        check("periodic_busy", int'(busy1), x.busy1);
        check("oneshot_tc_double",  ptc0 & int'(tc0), 0);
        check("periodic_tc_double", ptc1 & int'(tc1), 0);
        ptc0 = int'(tc0);
        ptc1 = int'(tc1);
      end
    end
  end

  initial begin : stim
    int dv;
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_rld[i] = 0; m_run[i] = 0; m_tc[i] = 0;
    end
    // Reset wins over load and enable, then nothing moves without a load.
    repeat (2) cyc(1, 1, 9, 1);
    repeat (5) cyc(0, 0, 0, 1);
    // Straight countdown from 5.
    cyc(0, 1, 5, 1);
    repeat (9) cyc(0, 0, 0, 1);
    // Gated enable.
    cyc(0, 1, 3, 0);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    // Short period, several wraps.
    cyc(0, 1, 2, 1);
    repeat (12) cyc(0, 0, 0, 1);
    // Reload mid-count, reset with load, zero load.
    cyc(0, 1, 7, 0);
    repeat (3) cyc(0, 0, 0, 1);
    cyc(0, 1, 7, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 1, 7, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 1);
    repeat (3) cyc(0, 0, 0, 1);
    // Full range.
    cyc(0, 1, 15, 1);
    repeat (20) cyc(0, 0, 0, 1);
    // Random traffic biased toward the edges of the range.
    for (int k = 0; k < 3000; k++) begin
      case ($urandom_range(0, 5))
        0:       dv = 0;
        1:       dv = 1;
        2:       dv = 15;
        default: dv = $urandom_range(0, 15);
      endcase
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 11) == 0), dv,
          ($urandom_range(0, 3) != 0));
    end
    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
